line_buffer_3row: RTL and testbench
===================================

// Module: line_buffer_3row
// PURPOSE
//  Raster-to-column converter feeding the 3x3 convolution stage. Accepts one pixel per
//  clock in raster order and emits three vertically aligned pixels (rows r-2, r-1, r)
//  of the same column, plus valid and end-of-line/end-of-frame markers.
//  Sits directly upstream of the 3x3 kernel block: pix_top/pix_mid/pix_bot feed it 1:1.
// PARAMETERS
//  PIXEL_WIDTH  8    bits per pixel (single colour channel)
//  IMG_WIDTH    640  pixels per line; >= 3
//  IMG_HEIGHT   480  lines per frame; >= 3
//  COLW         $clog2(IMG_WIDTH)   column counter width (derived, not overridden)
//  ROWW         $clog2(IMG_HEIGHT)  row counter width (derived, not overridden)
// PORTS
//  clk        in   1            pixel clock, rising edge
//  rst_n      in   1            asynchronous active-low reset
//  in_valid   in   1            in_pix carries a pixel this cycle
//  in_sof     in   1            start of frame; qualified by in_valid; marks pixel (0,0)
//  in_pix     in   PIXEL_WIDTH  raster pixel
//  pix_top    out  PIXEL_WIDTH  pixel at (row-2, col)
//  pix_mid    out  PIXEL_WIDTH  pixel at (row-1, col)
//  pix_bot    out  PIXEL_WIDTH  pixel at (row,   col)
//  out_valid  out  1            column triple valid this cycle
//  out_eol    out  1            with out_valid: col == IMG_WIDTH-1
//  out_eof    out  1            with out_valid: last column of last row
//  sof_err    out  1            1-cycle pulse: in_sof accepted while (row,col) != (0,0)
// BEHAVIOUR
//  - Reset: all outputs 0; col=0, row=0. Line RAM contents not cleared (masked by out_valid).
//  - Accept: a pixel is accepted when in_valid=1. No backpressure; in_valid gaps allowed.
//    With in_valid=0: counters hold, out_valid=0, data outputs hold their last values.
//  - Counters: on accept, col++; col==IMG_WIDTH-1 -> col=0, row++;
//    row==IMG_HEIGHT-1 and col==IMG_WIDTH-1 -> row=0, col=0 (implicit next frame).
//  - in_sof with in_valid: this pixel is (0,0); counters forced to (0,0) before increment.
//    If the pre-accept position was not (0,0), pulse sof_err next cycle. in_sof with
//    in_valid=0 is ignored.
//  - Storage: two line RAMs of IMG_WIDTH x PIXEL_WIDTH. LA holds row r-1, LB holds row r-2.
//    On accept at col c: read LA[c], LB[c]; write LB[c] <= old LA[c], LA[c] <= in_pix
//    (read-before-write at the same address, same cycle).
//  - Latency: exactly 1 clock from accept to outputs. in_pix is registered one stage to
//    align with the synchronous RAM read data.
//  - out_valid = registered (accept && row >= 2). Per frame: (IMG_HEIGHT-2)*IMG_WIDTH
//    triples. Rows 0,1 produce none. No border padding or flush.
//  - out_eol / out_eof: registered from the accepted pixel's position; 0 whenever
//    out_valid=0.
//  - Downstream contract: the 3x3 stage shifts every clock, so its output is meaningful
//    only for windows built from contiguous out_valid cycles within one line.
//    out_eol marks the line boundary.
//  - Reset mid-frame: immediate return to reset state; next frame begins at the first
//    accepted pixel (in_sof optional).
// STRUCTURE
//  - Shared package img_pkg: PIXEL_WIDTH, IMG_WIDTH, IMG_HEIGHT defaults; kernel mode
//    encoding (0=sharpen, 1=gaussian, 2=edge, 3=pass); pixel typedef.
//  - Sub-module line_ram: single-port, IMG_WIDTH deep, synchronous read-first,
//    with we/addr/din/dout. Instantiated twice (LA, LB).
//  - Top level: counters, sof check, in_pix alignment register, output registers.
// TESTING  (IMG_WIDTH=4, IMG_HEIGHT=4; pixel(r,c) = 16*r + c)
//  1. Assert rst_n=0 with random inputs -> all outputs 0; release -> out_valid stays 0
//     until row 2.
//  2. Contiguous frame with in_sof on the first pixel -> first out_valid 1 clk after
//     pixel (2,0), top=0x00 mid=0x10 bot=0x20. Exactly 8 valid cycles. Last has
//     top=0x13 mid=0x23 bot=0x33, out_eol=1, out_eof=1.
//  3. Same frame, in_valid toggling 1,0,1,0 -> identical 8 triples in order. out_valid
//     only 1 clk after an accept; data held during gaps.
//  4. in_sof with in_valid at pixel position (1,2) -> sof_err=1 for one clk. That pixel
//     becomes (0,0). No out_valid until 2 full rows after it.
//  5. rst_n pulsed low mid-row 3 -> out_valid=0 immediately. A fresh frame afterwards
//     gives the scenario-2 results.
//  6. Two back-to-back frames, no in_sof on the second -> second frame's 8 triples
//     equal the first's; sof_err never asserted.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: default frame geometry, the pixel type
// and the kernel-mode encoding used by the 3x3 convolution stage.
package img_pkg;

  localparam int DEF_PIXEL_WIDTH = 8;
  localparam int DEF_IMG_WIDTH   = 640;
  localparam int DEF_IMG_HEIGHT  = 480;

  typedef logic [DEF_PIXEL_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    KMODE_SHARPEN  = 2'd0,
    KMODE_GAUSSIAN = 2'd1,
    KMODE_EDGE     = 2'd2,
    KMODE_PASS     = 2'd3
  } kernel_mode_e;

endpackage

// File: rtl/line_ram.sv
// One line of pixel storage: single-port, synchronous read-first RAM.
// dout is the registered pre-write contents of the addressed word and only
// updates on an access (we=1), so it holds during input gaps. peek exposes the
// same pre-write word combinationally so a neighbouring line can be copied
// into another RAM in the same access cycle.
module line_ram
  import img_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_WIDTH,
  parameter int WIDTH = DEF_PIXEL_WIDTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] peek
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign peek = mem[addr];

  // Storage array: contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  // Read-first output register: captures the word before this cycle's write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  dout <= '0;
    else if (we) dout <= mem[addr];
  end

endmodule

// File: rtl/line_buffer_3row.sv
// Raster-to-column converter for the 3x3 kernel: emits rows r-2, r-1, r of
// the current column one clock after each accepted pixel, with valid and
// end-of-line / end-of-frame markers and a misplaced start-of-frame flag.
module line_buffer_3row
  import img_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
  localparam int COLW       = $clog2(IMG_WIDTH),
  localparam int ROWW       = $clog2(IMG_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [PIXEL_WIDTH-1:0] in_pix,
  output logic [PIXEL_WIDTH-1:0] pix_top,
  output logic [PIXEL_WIDTH-1:0] pix_mid,
  output logic [PIXEL_WIDTH-1:0] pix_bot,
  output logic                   out_valid,
  output logic                   out_eol,
  output logic                   out_eof,
  output logic                   sof_err
);

  localparam logic [COLW-1:0] COL_LAST = COLW'(IMG_WIDTH - 1);
  localparam logic [ROWW-1:0] ROW_LAST = ROWW'(IMG_HEIGHT - 1);
  localparam logic [ROWW-1:0] ROW_FIRST_OUT = ROWW'(2);

  logic [COLW-1:0]        col_p0, col_cur;
  logic [ROWW-1:0]        row_p0, row_cur;
  logic                   sof_hit, last_col, last_row, emit;
  logic [PIXEL_WIDTH-1:0] pix_p1;
  logic [PIXEL_WIDTH-1:0] la_dout, la_peek, lb_dout, lb_peek_unused;

  assign sof_hit  = in_valid && in_sof;
  assign last_col = (col_cur == COL_LAST);
  assign last_row = (row_cur == ROW_LAST);
  assign emit     = in_valid && (row_cur >= ROW_FIRST_OUT);

  // Effective position of the incoming pixel: a qualified sof forces (0,0).
  always_comb begin
    col_cur = col_p0;
    row_cur = row_p0;
    if (sof_hit) begin
      col_cur = '0;
      row_cur = '0;
    end
  end

  // Raster position counters; wrap at end of frame to start the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (in_valid) begin
      if (last_col) begin
        col_p0 <= '0;
        row_p0 <= last_row ? '0 : row_cur + 1'b1;
      end else begin
        col_p0 <= col_cur + 1'b1;
        row_p0 <= row_cur;
      end
    end
  end

  // LA holds row r-1; each access replaces it with the incoming pixel.
  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_line_a (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (in_valid),
    .addr (col_cur),
    .din  (in_pix),
    .dout (la_dout),
    .peek (la_peek)
  );

  // LB holds row r-2; each access replaces it with LA's pre-write word.
  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_line_b (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (in_valid),
    .addr (col_cur),
    .din  (la_peek),
    .dout (lb_dout),
    .peek (lb_peek_unused)
  );

  // ---- stage p0 -> p1: align the live pixel with the RAM read data ----
  // Current-row pixel register; holds through input gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pix_p1 <= '0;
    else if (in_valid) pix_p1 <= in_pix;
  end

  // Output control: valid, line/frame markers and the sof position check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      out_valid <= emit;
      out_eol   <= emit && last_col;
      out_eof   <= emit && last_col && last_row;
      sof_err   <= sof_hit && ((col_p0 != '0) || (row_p0 != '0));
    end
  end

  assign pix_top = lb_dout;
  assign pix_mid = la_dout;
  assign pix_bot = pix_p1;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Scoreboard bench for line_buffer_3row on a 4x4 image, pixel(r,c) = 16*r + c.
module tb_line_buffer_3row;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [PW-1:0] in_pix = '0;
  logic [PW-1:0] pix_top, pix_mid, pix_bot;
  logic          out_valid, out_eol, out_eof, sof_err;

  line_buffer_3row #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_pix   (in_pix),
    .pix_top  (pix_top),
    .pix_mid  (pix_mid),
    .pix_bot  (pix_bot),
    .out_valid(out_valid),
    .out_eol  (out_eol),
    .out_eof  (out_eof),
    .sof_err  (sof_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] top;
    logic [PW-1:0] mid;
    logic [PW-1:0] bot;
    logic          eol;
    logic          eof;
  } trip_t;

  trip_t sb[$];
  trip_t last_e;
  int    checks = 0;
  int    errors = 0;
  int    mr = 0;
  int    mc = 0;
  int    vcount = 0;
  int    errcount = 0;
  bit    hold_ok = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: drive inputs, predict, tick, compare.
  task automatic step(input bit v, input bit sof);
    trip_t e;
    bit    exp_v = 0;
    bit    exp_err = 0;
    in_valid = v;
    in_sof   = sof;
    if (v) begin
      if (sof) begin
        if (mr != 0 || mc != 0) exp_err = 1;
        mr = 0;
        mc = 0;
      end
      in_pix = PW'(16 * mr + mc);
      if (mr >= 2) begin
        e.top = PW'(16 * (mr - 2) + mc);
        e.mid = PW'(16 * (mr - 1) + mc);
        e.bot = PW'(16 * mr + mc);
        e.eol = (mc == W - 1);
        e.eof = (mc == W - 1) && (mr == H - 1);
        sb.push_back(e);
        exp_v = 1;
      end
      hold_ok = exp_v;
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
        mc = mc + 1;
      end
    end else begin
      in_pix = PW'($urandom);
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, exp_v);
    chk("sof_err", sof_err, exp_err);
    if (sof_err) errcount++;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("pix_top", pix_top, e.top);
        chk("pix_mid", pix_mid, e.mid);
        chk("pix_bot", pix_bot, e.bot);
        chk("out_eol", out_eol, e.eol);
        chk("out_eof", out_eof, e.eof);
        last_e = e;
        vcount++;
      end
    end else begin
      chk("eol_idle", out_eol, 0);
      chk("eof_idle", out_eof, 0);
      if (!v && hold_ok) begin
        chk("hold_top", pix_top, last_e.top);
        chk("hold_mid", pix_mid, last_e.mid);
        chk("hold_bot", pix_bot, last_e.bot);
      end
    end
    in_valid = 0;
    in_sof   = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_top"}, pix_top, 0);
    chk({tag, "_mid"}, pix_mid, 0);
    chk({tag, "_bot"}, pix_bot, 0);
    chk({tag, "_vld"}, out_valid, 0);
    chk({tag, "_eol"}, out_eol, 0);
    chk({tag, "_eof"}, out_eof, 0);
    chk({tag, "_err"}, sof_err, 0);
  endtask

  task automatic apply_reset();
    rst_n = 0;
    sb.delete();
    mr = 0;
    mc = 0;
    hold_ok = 0;
    repeat (3) begin
      in_valid = 1'($urandom);
      in_sof   = 1'($urandom);
      in_pix   = PW'($urandom);
      @(posedge clk);
      #1;
    end
    check_zero("rst");
    in_valid = 0;
    in_sof   = 0;
    rst_n    = 1;
  endtask

  task automatic frame(input bit gaps, input bit sof_first);
    for (int i = 0; i < W * H; i++) begin
      step(1, sof_first && (i == 0));
      if (gaps) step(0, 0);
    end
  endtask

  initial begin
    #2;
    // Reset with random inputs, then a contiguous frame.
    apply_reset();
    vcount = 0;
    frame(0, 1);
    chk("s2_count", vcount, 8);
    chk("s2_last_top", last_e.top, 8'h13);
    chk("s2_last_bot", last_e.bot, 8'h33);
    chk("s2_sb_empty", sb.size(), 0);

    // Same frame with gaps between every pixel.
    vcount = 0;
    frame(1, 1);
    chk("s3_count", vcount, 8);

    // Misplaced sof at (1,2); sof without valid is ignored.
    for (int i = 0; i < 6; i++) step(1, 0);
    step(0, 1);
    step(1, 1);
    vcount = 0;
    for (int i = 0; i < W * H - 1; i++) step(1, 0);
    chk("s4_count", vcount, 8);

    // Reset in the middle of row 3, then a fresh frame.
    step(1, 1);
    while (!(mr == 3 && mc == 2)) step(1, 0);
    rst_n = 0;
    #1;
    chk("s5_async_vld", out_valid, 0);
    chk("s5_async_bot", pix_bot, 0);
    apply_reset();
    vcount = 0;
    frame(0, 1);
    chk("s5_count", vcount, 8);
    chk("s5_last_eof", last_e.eof, 1);

    // Two back-to-back frames, sof only on the first.
    vcount = 0;
    errcount = 0;
    frame(0, 1);
    frame(0, 0);
    chk("s6_count", vcount, 16);
    chk("s6_no_err", errcount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
